// File: rtl/imem_loader_if.sv
// Host-to-loader instruction beat channel plus the instruction-memory port,
// bundled so the loader sees one bus; master = host/memory side, slave = loader.
interface imem_loader_if #(
  parameter int ADDR_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_op;
  logic [3:0]        in_f1;
  logic [3:0]        in_f2;
  logic [3:0]        in_f3;
  logic [11:0]       in_imm;
  logic              in_last;
  logic              imem_wen;
  logic [ADDR_W-1:0] imem_addr;
  logic [15:0]       imem_wdata;
  logic [15:0]       imem_rdata;

  modport master (
    output in_valid, in_op, in_f1, in_f2, in_f3, in_imm, in_last, imem_rdata,
    input  in_ready, imem_wen, imem_addr, imem_wdata
  );

  modport slave (
    input  in_valid, in_op, in_f1, in_f2, in_f3, in_imm, in_last, imem_rdata,
    output in_ready, imem_wen, imem_addr, imem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Packs structured instruction fields into 16-bit words and writes them to
// consecutive instruction-memory addresses. Define LOADER_READBACK_EN to verify each write.
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  imem_loader_if.slave      bus,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W:0] DEPTH_C = {1'b1, {ADDR_W{1'b0}}};

`ifdef LOADER_READBACK_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACCEPT = 3'd1,
    S_WRITE  = 3'd2,
    S_DONE   = 3'd3,
    S_READ   = 3'd4,
    S_CHECK  = 3'd5
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCEPT = 2'd1,
    S_WRITE  = 2'd2,
    S_DONE   = 2'd3
  } state_t;
`endif

  function automatic logic is_legal(input logic [3:0] op);
    return (op < 4'd14);
  endfunction

  // Every format except JUMP/JAL and JR places f1,f2,f3 in the three low nibbles.
  function automatic logic [15:0] encode(input logic [3:0] op, input logic [3:0] f1,
                                         input logic [3:0] f2, input logic [3:0] f3,
                                         input logic [11:0] imm);
    logic [15:0] w;
    case (op)
      4'd11, 4'd13: w = {op, imm};
      4'd12:        w = {op, f1, 8'h00};
      4'd14, 4'd15: w = 16'h0000;
      default:      w = {op, f1, f2, f3};
    endcase
    return w;
  endfunction

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [15:0]       word_q, word_d;
  logic              last_q, last_d;
  logic              err_q, err_d;
  logic [1:0]        code_q, code_d;
  logic              in_ready_q, in_ready_d;
  logic              wen_q, wen_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

`ifndef LOADER_READBACK_EN
  logic rdata_unused;
  assign rdata_unused = ^bus.imem_rdata;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    waddr_d = waddr_q;
    count_d = count_q;
    word_d  = word_q;
    last_d  = last_q;
    err_d   = err_q;
    code_d  = code_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ACCEPT;
          addr_d  = base_addr;
          count_d = {(ADDR_W+1){1'b0}};
          err_d   = 1'b0;
          code_d  = 2'b00;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACCEPT: begin
        if (bus.in_valid) begin
          if (!is_legal(bus.in_op)) begin
            err_d   = 1'b1;
            code_d  = 2'b01;
            state_d = S_DONE;
          end else if (count_q == DEPTH_C) begin
            err_d   = 1'b1;
            code_d  = 2'b10;
            state_d = S_DONE;
          end else begin
            word_d  = encode(bus.in_op, bus.in_f1, bus.in_f2, bus.in_f3, bus.in_imm);
            last_d  = bus.in_last;
            waddr_d = addr_q;
            state_d = S_WRITE;
          end
        end else begin
          state_d = S_ACCEPT;
        end
      end
      S_WRITE: begin
        addr_d  = addr_q + ADDR_W'(1);
        count_d = count_q + (ADDR_W+1)'(1);
`ifdef LOADER_READBACK_EN
        state_d = S_READ;
`else
        if (last_q) begin
          state_d = S_DONE;
        end else begin
          state_d = S_ACCEPT;
        end
`endif
      end
`ifdef LOADER_READBACK_EN
      S_READ: begin
        state_d = S_CHECK;
      end
      // Read data for the address presented in READ arrives during CHECK.
      S_CHECK: begin
        if (bus.imem_rdata != word_q) begin
          err_d   = 1'b1;
          code_d  = 2'b11;
          state_d = S_DONE;
        end else if (last_q) begin
          state_d = S_DONE;
        end else begin
          state_d = S_ACCEPT;
        end
      end
`endif
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    in_ready_d = (state_d == S_ACCEPT);
    wen_d      = (state_d == S_WRITE);
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE);
  end

  // State and registered outputs; outputs are decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= {ADDR_W{1'b0}};
      waddr_q    <= {ADDR_W{1'b0}};
      count_q    <= {(ADDR_W+1){1'b0}};
      word_q     <= 16'h0000;
      last_q     <= 1'b0;
      err_q      <= 1'b0;
      code_q     <= 2'b00;
      in_ready_q <= 1'b0;
      wen_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      waddr_q    <= waddr_d;
      count_q    <= count_d;
      word_q     <= word_d;
      last_q     <= last_d;
      err_q      <= err_d;
      code_q     <= code_d;
      in_ready_q <= in_ready_d;
      wen_q      <= wen_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.imem_wen   = wen_q;
  assign bus.imem_addr  = waddr_q;
  assign bus.imem_wdata = word_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign err            = err_q;
  assign err_code       = code_q;
  assign count          = count_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: an 8-bit-address instance for the main
// scenarios and a 2-bit-address instance for wrap/overflow; writes are scoreboarded.
module tb_imem_loader;

`ifdef LOADER_READBACK_EN
  localparam int DONE_STEPS = 3;
`else
  localparam int DONE_STEPS = 1;
`endif

  typedef struct packed {
    logic [7:0]  addr;
    logic [15:0] data;
  } wr_t;

  logic       clk;
  logic       rst_n;
  logic       start8, start2;
  logic [7:0] base8;
  logic [1:0] base2;
  logic       busy8, done8, err8, busy2, done2, err2;
  logic [1:0] code8, code2;
  logic [8:0] count8;
  logic [2:0] count2;
  logic       corrupt;

  int  checks   = 0;
  int  failures = 0;
  wr_t wq8[$];
  wr_t wq2[$];
  wr_t e8, e2;
  logic [15:0] mem8 [256];
  logic [15:0] mem2 [4];

  imem_loader_if #(.ADDR_W(8)) bus8 ();
  imem_loader_if #(.ADDR_W(2)) bus2 ();

  imem_loader #(.ADDR_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .base_addr(base8), .bus(bus8.slave),
    .busy(busy8), .done(done8), .err(err8), .err_code(code8), .count(count8)
  );

  imem_loader #(.ADDR_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .base_addr(base2), .bus(bus2.slave),
    .busy(busy2), .done(done2), .err(err2), .err_code(code2), .count(count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus8.imem_wen) mem8[bus8.imem_addr] <= bus8.imem_wdata;
    bus8.imem_rdata <= mem8[bus8.imem_addr] ^ {15'd0, corrupt};
    if (bus2.imem_wen) mem2[bus2.imem_addr] <= bus2.imem_wdata;
    bus2.imem_rdata <= mem2[bus2.imem_addr];
  end

  always @(negedge clk) begin
    if (rst_n && bus8.imem_wen === 1'b1) begin
      checks++;
      if (wq8.size() == 0) begin
        failures++;
        $display("FAIL wr8_unexpected got addr=%h data=%h, none expected", bus8.imem_addr, bus8.imem_wdata);
      end else begin
        e8 = wq8.pop_front();
        if ({bus8.imem_addr, bus8.imem_wdata} !== {e8.addr, e8.data}) begin
          failures++;
          $display("FAIL wr8 got addr=%h data=%h expected addr=%h data=%h",
                   bus8.imem_addr, bus8.imem_wdata, e8.addr, e8.data);
        end
      end
    end
    if (rst_n && bus2.imem_wen === 1'b1) begin
      checks++;
      if (wq2.size() == 0) begin
        failures++;
        $display("FAIL wr2_unexpected got addr=%h data=%h, none expected", bus2.imem_addr, bus2.imem_wdata);
      end else begin
        e2 = wq2.pop_front();
        if ({6'd0, bus2.imem_addr, bus2.imem_wdata} !== {e2.addr, e2.data}) begin
          failures++;
          $display("FAIL wr2 got addr=%h data=%h expected addr=%h data=%h",
                   bus2.imem_addr, bus2.imem_wdata, e2.addr, e2.data);
        end
      end
    end
  end

  function automatic logic [15:0] exp_word(input logic [3:0] op, input logic [3:0] f1,
                                           input logic [3:0] f2, input logic [3:0] f3,
                                           input logic [11:0] imm);
    if (op == 4'd11 || op == 4'd13) return {op, imm};
    else if (op == 4'd12) return {op, f1, 8'h00};
    else return {op, f1, f2, f3};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input bit to2, input logic [7:0] base);
    if (to2) begin start2 = 1'b1; base2 = base[1:0]; end
    else begin start8 = 1'b1; base8 = base; end
    step();
    start8 = 1'b0;
    start2 = 1'b0;
  endtask

  task automatic send_beat(input bit to2, input logic [3:0] op, input logic [3:0] f1,
                           input logic [3:0] f2, input logic [3:0] f3,
                           input logic [11:0] imm, input logic last);
    int n = 0;
    while ((to2 ? bus2.in_ready : bus8.in_ready) !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    checks++;
    if ((to2 ? bus2.in_ready : bus8.in_ready) !== 1'b1) begin
      failures++;
      $display("FAIL ready_timeout dut=%0d got in_ready=0 expected 1 within 20 cycles", to2 ? 2 : 8);
    end
    if (to2) begin
      bus2.in_op = op; bus2.in_f1 = f1; bus2.in_f2 = f2; bus2.in_f3 = f3;
      bus2.in_imm = imm; bus2.in_last = last; bus2.in_valid = 1'b1;
    end else begin
      bus8.in_op = op; bus8.in_f1 = f1; bus8.in_f2 = f2; bus8.in_f3 = f3;
      bus8.in_imm = imm; bus8.in_last = last; bus8.in_valid = 1'b1;
    end
    step();
    bus8.in_valid = 1'b0;
    bus2.in_valid = 1'b0;
    bus8.in_last  = 1'b0;
    bus2.in_last  = 1'b0;
  endtask

  task automatic wait_done8(output bit ok);
    int n = 0;
    while (done8 !== 1'b1 && n < 30) begin
      step();
      n++;
    end
    ok = (done8 === 1'b1);
  endtask

  task automatic test_reset();
    checks++;
    if ({bus8.in_ready, bus8.imem_wen, bus8.imem_addr, bus8.imem_wdata, busy8, done8, err8, code8, count8} !== 40'd0) begin
      failures++;
      $display("FAIL reset8 got rdy=%b wen=%b addr=%h wdata=%h busy=%b done=%b err=%b code=%b count=%0d expected all zero",
               bus8.in_ready, bus8.imem_wen, bus8.imem_addr, bus8.imem_wdata, busy8, done8, err8, code8, count8);
    end
    checks++;
    if ({bus2.in_ready, bus2.imem_wen, bus2.imem_addr, bus2.imem_wdata, busy2, done2, err2, code2, count2} !== 28'd0) begin
      failures++;
      $display("FAIL reset2 got rdy=%b wen=%b busy=%b done=%b count=%0d expected all zero",
               bus2.in_ready, bus2.imem_wen, busy2, done2, count2);
    end
  endtask

  task automatic test_add();
    bus8.in_op = 4'd0; bus8.in_valid = 1'b1;
    step();
    checks++;
    if (bus8.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL idle_ready got %b expected 0", bus8.in_ready);
    end
    step();
    bus8.in_valid = 1'b0;
    do_start(1'b0, 8'h10);
    checks++;
    if ({busy8, bus8.in_ready} !== 2'b11) begin
      failures++;
      $display("FAIL add_start got busy=%b rdy=%b expected 1 1", busy8, bus8.in_ready);
    end
    wq8.push_back('{8'h10, 16'h0123});
    send_beat(1'b0, 4'd0, 4'd1, 4'd2, 4'd3, 12'h000, 1'b1);
    checks++;
    if ({bus8.imem_wen, bus8.in_ready} !== 2'b10) begin
      failures++;
      $display("FAIL add_wen got wen=%b rdy=%b expected 1 0", bus8.imem_wen, bus8.in_ready);
    end
    repeat (DONE_STEPS) step();
    checks++;
    if ({done8, err8, count8} !== {1'b1, 1'b0, 9'd1}) begin
      failures++;
      $display("FAIL add_done got done=%b err=%b count=%0d expected done=1 err=0 count=1", done8, err8, count8);
    end
    step();
    checks++;
    if ({done8, busy8} !== 2'b00) begin
      failures++;
      $display("FAIL add_end got done=%b busy=%b expected 0 0", done8, busy8);
    end
  endtask

  task automatic test_jump();
    bit ok;
    do_start(1'b0, 8'h00);
    wq8.push_back('{8'h00, 16'hBABC});
    send_beat(1'b0, 4'd11, 4'd0, 4'd0, 4'd0, 12'hABC, 1'b0);
    do_start(1'b0, 8'h77);
    wq8.push_back('{8'h01, 16'hC500});
    send_beat(1'b0, 4'd12, 4'd5, 4'd0, 4'd0, 12'h000, 1'b1);
    wait_done8(ok);
    checks++;
    if (!ok || count8 !== 9'd2 || err8 !== 1'b0) begin
      failures++;
      $display("FAIL jump_done got done=%b count=%0d err=%b expected 1 2 0", done8, count8, err8);
    end
    step();
  endtask

  task automatic test_illegal();
    bit ok;
    do_start(1'b0, 8'h20);
    wq8.push_back('{8'h20, exp_word(4'd1, 4'd4, 4'd5, 4'd6, 12'h000)});
    send_beat(1'b0, 4'd1, 4'd4, 4'd5, 4'd6, 12'h000, 1'b0);
    send_beat(1'b0, 4'd14, 4'd1, 4'd1, 4'd1, 12'h000, 1'b0);
    checks++;
    if ({done8, err8, code8, count8, bus8.imem_wen} !== {1'b1, 1'b1, 2'b01, 9'd1, 1'b0}) begin
      failures++;
      $display("FAIL illegal got done=%b err=%b code=%b count=%0d wen=%b expected 1 1 01 1 0",
               done8, err8, code8, count8, bus8.imem_wen);
    end
    step();
    do_start(1'b0, 8'h30);
    checks++;
    if ({err8, code8} !== 3'b000) begin
      failures++;
      $display("FAIL err_clear got err=%b code=%b expected 0 00", err8, code8);
    end
    wq8.push_back('{8'h30, exp_word(4'd9, 4'd7, 4'd8, 4'd9, 12'h000)});
    send_beat(1'b0, 4'd9, 4'd7, 4'd8, 4'd9, 12'h000, 1'b1);
    wait_done8(ok);
    checks++;
    if (!ok || count8 !== 9'd1) begin
      failures++;
      $display("FAIL illegal_next got done=%b count=%0d expected 1 1", done8, count8);
    end
    step();
  endtask

  task automatic test_overflow();
    logic [1:0] a;
    logic [3:0] op;
    do_start(1'b1, 8'h03);
    a = 2'd3;
    for (int i = 0; i < 4; i++) begin
      op = (i == 3) ? 4'd13 : 4'(i + 5);
      wq2.push_back('{{6'd0, a}, exp_word(op, 4'(i), 4'(i + 1), 4'(i + 2), 12'(12'h5A0 + i))});
      send_beat(1'b1, op, 4'(i), 4'(i + 1), 4'(i + 2), 12'(12'h5A0 + i), 1'b0);
      a = a + 2'd1;
    end
    send_beat(1'b1, 4'd0, 4'd1, 4'd1, 4'd1, 12'h000, 1'b0);
    checks++;
    if ({done2, err2, code2, count2, bus2.imem_wen} !== {1'b1, 1'b1, 2'b10, 3'd4, 1'b0}) begin
      failures++;
      $display("FAIL overflow got done=%b err=%b code=%b count=%0d wen=%b expected 1 1 10 4 0",
               done2, err2, code2, count2, bus2.imem_wen);
    end
    step();
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_start(1'b0, 8'h40);
    send_beat(1'b0, 4'd2, 4'd3, 4'd3, 4'd3, 12'h000, 1'b0);
    checks++;
    if (bus8.imem_wen !== 1'b1) begin
      failures++;
      $display("FAIL mid_write got wen=%b expected 1", bus8.imem_wen);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus8.in_ready, bus8.imem_wen, bus8.imem_addr, bus8.imem_wdata, busy8, done8, err8, code8, count8} !== 40'd0) begin
      failures++;
      $display("FAIL mid_reset got wen=%b addr=%h wdata=%h busy=%b count=%0d expected all zero",
               bus8.imem_wen, bus8.imem_addr, bus8.imem_wdata, busy8, count8);
    end
    step();
    rst_n = 1'b1;
    step();
    do_start(1'b0, 8'h50);
    wq8.push_back('{8'h50, exp_word(4'd10, 4'd1, 4'd2, 4'd7, 12'h000)});
    send_beat(1'b0, 4'd10, 4'd1, 4'd2, 4'd7, 12'h000, 1'b1);
    wait_done8(ok);
    checks++;
    if (!ok || count8 !== 9'd1 || err8 !== 1'b0) begin
      failures++;
      $display("FAIL post_reset got done=%b count=%0d err=%b expected 1 1 0", done8, count8, err8);
    end
    step();
  endtask

`ifdef LOADER_READBACK_EN
  task automatic test_readback();
    corrupt = 1'b1;
    do_start(1'b0, 8'h60);
    wq8.push_back('{8'h60, exp_word(4'd7, 4'd2, 4'd4, 4'd6, 12'h000)});
    send_beat(1'b0, 4'd7, 4'd2, 4'd4, 4'd6, 12'h000, 1'b1);
    step();
    step();
    checks++;
    if (done8 !== 1'b0) begin
      failures++;
      $display("FAIL rb_early got done=%b expected 0", done8);
    end
    step();
    checks++;
    if ({done8, err8, code8} !== {1'b1, 1'b1, 2'b11}) begin
      failures++;
      $display("FAIL readback got done=%b err=%b code=%b expected 1 1 11", done8, err8, code8);
    end
    corrupt = 1'b0;
    step();
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    start8 = 1'b0; start2 = 1'b0; base8 = 8'h00; base2 = 2'd0; corrupt = 1'b0;
    bus8.in_valid = 1'b0; bus8.in_op = 4'd0; bus8.in_f1 = 4'd0; bus8.in_f2 = 4'd0;
    bus8.in_f3 = 4'd0; bus8.in_imm = 12'h000; bus8.in_last = 1'b0;
    bus2.in_valid = 1'b0; bus2.in_op = 4'd0; bus2.in_f1 = 4'd0; bus2.in_f2 = 4'd0;
    bus2.in_f3 = 4'd0; bus2.in_imm = 12'h000; bus2.in_last = 1'b0;
    repeat (3) step();
    test_reset();
    rst_n = 1'b1;
    step();
    test_add();
    test_jump();
    test_illegal();
    test_overflow();
    test_reset_mid();
`ifdef LOADER_READBACK_EN
    test_readback();
`endif
    repeat (2) step();
    checks++;
    if (wq8.size() != 0 || wq2.size() != 0) begin
      failures++;
      $display("FAIL missing_writes got pending8=%0d pending2=%0d expected 0 0", wq8.size(), wq2.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Sequential program loader that is the encoding counterpart of the opcode decoder in the control path. It accepts structured instruction fields from a host or bench over a valid/ready handshake, packs them into 16-bit instruction words using the fixed ISA encoding, and writes them into consecutive instruction-memory locations. It sits between the host/debug port and the instruction memory's write port, and is used only while the core is held idle.

## Interface
Parameters:
- ADDR_W, 8, instruction-memory address width; DEPTH = 2**ADDR_W words.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  begin a load session; sampled only in IDLE
- base_addr  in  ADDR_W  first write address, latched on start
- in_valid  in  1  instruction beat valid
- in_ready  out  1  loader can take a beat
- in_op  in  4  opcode
- in_f1, in_f2, in_f3  in  4 each  register/immediate fields
- in_imm  in  12  jump target (JUMP/JAL only)
- in_last  in  1  final beat of the session
- imem_wen  out  1  memory write strobe
- imem_addr  out  ADDR_W  memory address
- imem_wdata  out  16  encoded instruction
- imem_rdata  in  16  memory read data, one-cycle synchronous read latency
- busy  out  1  session in progress
- done  out  1  one-cycle pulse at session end
- err  out  1  sticky error, cleared on next accepted start
- err_code  out  2  00 none, 01 illegal opcode, 10 overflow, 11 readback mismatch
- count  out  ADDR_W+1  words written this session

## Operation
- Opcodes: ADD 0, SUB 1, AND 2, XOR 3, COM 4, SLL 5, SRL 6, MUL 7, LW 8, SW 9, BEQ 10, JUMP 11, JR 12, JAL 13; 14 and 15 illegal.
- Encoding: ALU ops 0-4,7 {op,rd=f1,rs=f2,rt=f3}; SLL/SRL {op,rd=f1,rs=f2,shamt=f3}; LW/SW {op,rt=f1,rs=f2,off=f3}; BEQ {op,rs=f1,rt=f2,off=f3}; JUMP/JAL {op,in_imm}; JR {op,rs=f1,8'h00}.
- States: IDLE, ACCEPT, WRITE, DONE (+READ, CHECK with readback).
- IDLE: start -> latch base_addr, count=0, clear err/err_code, go ACCEPT.
- ACCEPT: in_ready=1; on in_valid&in_ready register encoded word and in_last. Illegal op -> err=1, code 01, DONE, no write. count==DEPTH -> err=1, code 10, DONE, no write. Else WRITE.
- WRITE: imem_wen=1 for exactly one cycle at current address; then address+1 (modulo DEPTH, wraps past all-ones), count+1; go READ if readback enabled, else DONE if last else ACCEPT.
- DONE: done=1 one cycle, busy=0 next cycle, return IDLE.
- start outside IDLE ignored. in_valid outside ACCEPT ignored (in_ready=0).

## Timing
- Reset values: in_ready 0, imem_wen 0, imem_addr 0, imem_wdata 0, busy 0, done 0, err 0, err_code 00, count 0; state IDLE.
- busy high from cycle after start through DONE cycle.
- Beat accepted in cycle N -> imem_wen in N+1 -> next in_ready in N+2 (2 cycles/word; 4 with readback).
- Last beat accepted in N -> write N+1 -> done N+2 (N+4 with readback).
- Reset mid-session: immediate return to reset values; words already written stay in memory.

## Configuration
- LOADER_READBACK_EN defined: after WRITE, READ drives imem_addr = written address with imem_wen=0; CHECK compares imem_rdata with registered word; mismatch -> err=1, code 11, DONE; match -> DONE if last else ACCEPT.
- Undefined: READ/CHECK absent, imem_rdata unused, code 11 never produced.

## Test plan
- start, base 0x10; ADD f1=1 f2=2 f3=3, last -> one imem_wen at 0x10 with 0x0123, done 2 cycles after accept, count 1.
- JUMP imm 0xABC then JR f1=5 last from base 0x00 -> writes 0xBABC@0x00, 0xC500@0x01, count 2.
- Op 14 as second beat -> no second write, err=1, code 01, done pulse, count 1.
- ADDR_W=2, base 3, 5 beats -> writes at 3,0,1,2 (wrap), 5th beat gives code 10, count 4.
- Reset asserted during WRITE -> all outputs at reset values next edge; new start clears err.
- With LOADER_READBACK_EN, memory model corrupts bit 0 -> err=1, code 11, done 4 cycles after accept.
